mbox_req_ctl: RTL and testbench

MBOX_REQ_CTL -- requirements
Module: mbox_req_ctl

---
 rtl/mbox_req_ctl.sv | 104 ++++++++++
 tb/tb_mbox_req_ctl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbox_req_ctl.sv
// mbox_req_ctl: EBOX-to-memory request controller with a fast-AC file, NXM timeout and read-pause-write interlock.
module mbox_req_ctl #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         eboxReq,
    input  logic         eboxRead,
    input  logic         eboxWrite,
    input  logic         eboxPSE,
    input  logic         vmaACRef,
    input  logic [13:35] eboxVMA,
    input  logic [0:35]  cacheDataWrite,
    output logic [0:35]  cacheDataRead,
    output logic         mboxRespIn,
    output logic         mboxBusy,
    output logic         memReq,
    output logic         memWrite,
    output logic [13:35] memAdr,
    output logic [0:35]  memDataOut,
    input  logic [0:35]  memDataIn,
    input  logic         memAck,
    output logic         memLock,
    output logic         nxmErr
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, AC, MEMWAIT, RESP, PSE_HOLD} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic            wr_q;
    logic            pse_q;
    logic [0:35]     ac_file [16];
    logic            accept;
    logic            pse_wr;
    logic            pse_rd;
    logic            timeout;
    logic            unused_ok;

    // A request with neither read nor write set completes as a read, so eboxRead carries no extra information.
    assign unused_ok = eboxRead;

    assign accept  = state == IDLE && eboxReq;
    assign pse_wr  = state == PSE_HOLD && eboxReq && eboxWrite;
    assign pse_rd  = eboxPSE && !eboxWrite && !vmaACRef;
    assign timeout = state == MEMWAIT && !memAck && cnt == CNT_LAST;

    assign mboxBusy   = state != IDLE;
    assign memReq     = state == MEMWAIT;
    assign memWrite   = memReq && wr_q;
    assign mboxRespIn = state == AC || state == RESP;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (eboxReq) state_n = vmaACRef ? AC : MEMWAIT;
            AC:       state_n = IDLE;
            MEMWAIT:  if (memAck || cnt == CNT_LAST) state_n = RESP;
            RESP:     state_n = pse_q ? PSE_HOLD : IDLE;
            PSE_HOLD: if (eboxReq && eboxWrite) state_n = MEMWAIT;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_q          <= 1'b0;
            pse_q         <= 1'b0;
            memLock       <= 1'b0;
            nxmErr        <= 1'b0;
            cacheDataRead <= '0;
            memAdr        <= '0;
            memDataOut    <= '0;
        end else begin
            state  <= state_n;
            nxmErr <= timeout;
            cnt    <= (state == MEMWAIT && state_n == MEMWAIT) ? cnt + 1'b1 : '0;
            if (accept) begin
                memAdr     <= eboxVMA;
                memDataOut <= cacheDataWrite;
                wr_q       <= eboxWrite;
                pse_q      <= pse_rd;
                memLock    <= pse_rd;
                if (vmaACRef && !eboxWrite) cacheDataRead <= ac_file[eboxVMA[32:35]];
            end
            // The write half of a read-pause-write reuses the address latched by the read.
            if (pse_wr) begin
                memDataOut <= cacheDataWrite;
                wr_q       <= 1'b1;
                pse_q      <= 1'b0;
            end
            if (state == MEMWAIT && state_n == RESP && !wr_q) cacheDataRead <= memAck ? memDataIn : '0;
            if (state == RESP && !pse_q) memLock <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == AC && wr_q) ac_file[memAdr[32:35]] <= memDataOut;
    end
endmodule

// File: tb/tb_mbox_req_ctl.sv
// tb_mbox_req_ctl: transaction-level reference model for mbox_req_ctl with directed and randomized requests.
module tb_mbox_req_ctl;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         eboxReq = 1'b0, eboxRead = 1'b0, eboxWrite = 1'b0, eboxPSE = 1'b0, vmaACRef = 1'b0;
    logic [13:35] eboxVMA = '0;
    logic [0:35]  cacheDataWrite = '0;
    logic [0:35]  memDataIn = '0;
    logic         memAck = 1'b0;
    logic [0:35]  cacheDataRead;
    logic         mboxRespIn, mboxBusy, memReq, memWrite, memLock, nxmErr;
    logic [13:35] memAdr;
    logic [0:35]  memDataOut;

    int checks = 0;
    int errors = 0;

    logic [35:0] acm [16];
    logic [35:0] mem [logic [22:0]];
    logic [35:0] last_rd = '0;
    bit          pse_pend = 0;
    logic [22:0] pse_addr = '0;

    mbox_req_ctl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .eboxReq(eboxReq), .eboxRead(eboxRead), .eboxWrite(eboxWrite),
        .eboxPSE(eboxPSE), .vmaACRef(vmaACRef), .eboxVMA(eboxVMA), .cacheDataWrite(cacheDataWrite),
        .cacheDataRead(cacheDataRead), .mboxRespIn(mboxRespIn), .mboxBusy(mboxBusy), .memReq(memReq),
        .memWrite(memWrite), .memAdr(memAdr), .memDataOut(memDataOut), .memDataIn(memDataIn),
        .memAck(memAck), .memLock(memLock), .nxmErr(nxmErr)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] memval(input logic [22:0] a);
        return mem.exists(a) ? mem[a] : (36'(a) ^ 36'h5a5a5a5a5);
    endfunction

    // One EBOX request from acceptance through completion, with the memory acking dly cycles after memReq (-1 = never).
    task automatic xact(input bit acr, input bit rd, input bit wr, input bit pse,
                        input logic [22:0] vma, input logic [35:0] d, input int dly);
        bit          holdw = pse_pend;
        bit          mem_pse = pse && !wr && !acr && !pse_pend;
        logic [22:0] a = pse_pend ? pse_addr : vma;
        bit          acked = 0;
        eboxReq = 1; eboxRead = rd; eboxWrite = wr; eboxPSE = pse; vmaACRef = acr;
        eboxVMA = vma; cacheDataWrite = d;
        tick;
        eboxReq = 0; eboxVMA = 23'($urandom); cacheDataWrite = 36'($urandom);
        if (acr && !holdw) begin
            if (wr) acm[a[3:0]] = d;
            else last_rd = acm[a[3:0]];
            chk("ac_resp", 64'(mboxRespIn), 64'(1));
            chk("ac_busy", 64'(mboxBusy), 64'(1));
            chk("ac_memreq", 64'(memReq), 64'(0));
            chk("ac_lock", 64'(memLock), 64'(0));
            chk("ac_rdata", 64'(cacheDataRead), 64'(last_rd));
            memAck = 1;
            tick;
            memAck = 0;
            chk("ac_resp_end", 64'(mboxRespIn), 64'(0));
            chk("ac_idle", 64'(mboxBusy), 64'(0));
            chk("ac_rdata_hold", 64'(cacheDataRead), 64'(last_rd));
            return;
        end
        for (int k = 0; k < TO; k++) begin
            chk("mw_req", 64'(memReq), 64'(1));
            chk("mw_adr", 64'(memAdr), 64'(a));
            chk("mw_wr", 64'(memWrite), 64'(wr));
            chk("mw_lock", 64'(memLock), 64'(mem_pse || holdw));
            chk("mw_resp", 64'(mboxRespIn), 64'(0));
            chk("mw_nxm", 64'(nxmErr), 64'(0));
            if (wr) chk("mw_wdata", 64'(memDataOut), 64'(d));
            if (k == dly) begin
                memAck = 1;
                memDataIn = wr ? 36'($urandom) : memval(a);
                acked = 1;
            end
            tick;
            memAck = 0;
            memDataIn = 36'($urandom);
            if (acked) break;
        end
        if (wr && acked) mem[a] = d;
        if (!wr) last_rd = acked ? memval(a) : '0;
        chk("rs_resp", 64'(mboxRespIn), 64'(1));
        chk("rs_req", 64'(memReq), 64'(0));
        chk("rs_nxm", 64'(nxmErr), 64'(!acked));
        chk("rs_rdata", 64'(cacheDataRead), 64'(last_rd));
        chk("rs_lock", 64'(memLock), 64'(mem_pse || holdw));
        tick;
        if (holdw) pse_pend = 0;
        else if (mem_pse) begin
            pse_pend = 1;
            pse_addr = a;
        end
        chk("dn_resp", 64'(mboxRespIn), 64'(0));
        chk("dn_nxm", 64'(nxmErr), 64'(0));
        chk("dn_req", 64'(memReq), 64'(0));
        chk("dn_lock", 64'(memLock), 64'(pse_pend));
        chk("dn_busy", 64'(mboxBusy), 64'(pse_pend));
        chk("dn_rdata", 64'(cacheDataRead), 64'(last_rd));
    endtask

    // Non-write requests and stray acks in PSE_HOLD must change nothing.
    task automatic hold_poke;
        eboxReq = 1; eboxRead = 1; eboxWrite = 0; vmaACRef = 1'($urandom); memAck = 1;
        tick;
        eboxReq = 0; memAck = 0;
        chk("hold_busy", 64'(mboxBusy), 64'(1));
        chk("hold_req", 64'(memReq), 64'(0));
        chk("hold_resp", 64'(mboxRespIn), 64'(0));
        chk("hold_lock", 64'(memLock), 64'(1));
        chk("hold_rdata", 64'(cacheDataRead), 64'(last_rd));
    endtask

    initial begin
        tick;
        tick;
        chk("rst_busy", 64'(mboxBusy), 64'(0));
        chk("rst_req", 64'(memReq), 64'(0));
        chk("rst_wr", 64'(memWrite), 64'(0));
        chk("rst_lock", 64'(memLock), 64'(0));
        chk("rst_resp", 64'(mboxRespIn), 64'(0));
        chk("rst_nxm", 64'(nxmErr), 64'(0));
        chk("rst_rdata", 64'(cacheDataRead), 64'(0));
        chk("rst_adr", 64'(memAdr), 64'(0));
        chk("rst_wdata", 64'(memDataOut), 64'(0));
        reset = 0;
        tick;

        for (int i = 0; i < 16; i++) xact(1, 0, 1, 0, 23'(i), 36'($urandom), 0);

        xact(1, 0, 1, 0, 23'd5, 36'o123456701234, 0);
        xact(1, 1, 0, 0, 23'd5, 36'($urandom), 0);
        chk("ac5_read", 64'(cacheDataRead), 64'(36'o123456701234));

        mem[23'o1000] = 36'o777;
        xact(0, 1, 0, 0, 23'o1000, 36'($urandom), 3);
        chk("mem_read", 64'(cacheDataRead), 64'(36'o777));

        xact(0, 1, 0, 0, 23'o4000, 36'($urandom), -1);
        chk("nxm_data", 64'(cacheDataRead), 64'(0));

        xact(0, 1, 0, 0, 23'o1000, 36'($urandom), TO - 1);
        xact(0, 1, 1, 0, 23'o1001, 36'o123, 0);
        xact(0, 0, 0, 0, 23'o1001, 36'($urandom), 1);
        chk("rw_as_write", 64'(cacheDataRead), 64'(36'o123));

        xact(0, 1, 0, 1, 23'o2000, 36'($urandom), 2);
        hold_poke;
        xact(0, 0, 1, 0, 23'o3000, 36'o4242, 1);
        chk("pse_write_adr", 64'(mem.exists(23'o2000) ? mem[23'o2000] : 36'h0), 64'(36'o4242));
        xact(1, 1, 0, 1, 23'd5, 36'($urandom), 0);

        for (int n = 0; n < 60; n++) begin
            bit          acr = 1'($urandom);
            logic [22:0] v = acr ? 23'($urandom) : 23'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
            int          dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            if (pse_pend) begin
                if ($urandom_range(0, 1) == 1) hold_poke;
                xact(acr, 1'($urandom), 1, 1'($urandom), v, 36'($urandom), dly);
            end else begin
                xact(acr, 1'($urandom), 1'($urandom), 1'($urandom), v, 36'($urandom), dly);
            end
            repeat ($urandom_range(0, 2)) tick;
        end
        if (pse_pend) xact(0, 0, 1, 0, 23'd0, 36'($urandom), 0);

        eboxReq = 1; eboxRead = 1; eboxWrite = 0; eboxPSE = 1; vmaACRef = 0; eboxVMA = 23'o5000;
        tick;
        eboxReq = 0;
        chk("rr_req", 64'(memReq), 64'(1));
        chk("rr_lock", 64'(memLock), 64'(1));
        eboxReq = 1; vmaACRef = 1; eboxVMA = 23'o6001;
        tick;
        eboxReq = 0;
        chk("rr_ignored_req", 64'(memReq), 64'(1));
        chk("rr_ignored_adr", 64'(memAdr), 64'(23'o5000));
        chk("rr_ignored_resp", 64'(mboxRespIn), 64'(0));
        reset = 1;
        tick;
        reset = 0;
        last_rd = '0;
        pse_pend = 0;
        chk("rr_memreq", 64'(memReq), 64'(0));
        chk("rr_busy", 64'(mboxBusy), 64'(0));
        chk("rr_lock0", 64'(memLock), 64'(0));
        chk("rr_rdata", 64'(cacheDataRead), 64'(0));
        chk("rr_adr0", 64'(memAdr), 64'(0));
        for (int i = 0; i < 3; i++) begin
            chk("rr_no_resp", 64'(mboxRespIn), 64'(0));
            chk("rr_no_nxm", 64'(nxmErr), 64'(0));
            tick;
        end

        xact(1, 1, 0, 0, 23'd5, 36'($urandom), 0);
        xact(0, 1, 0, 0, 23'o1001, 36'($urandom), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
